pixel_shifter: RTL
==================

Name: pixel_shifter

Overview:
Parametrised successor to the single-mode semigraphics shifter. Serialises display bytes into per-pixel colour indices for the downstream colour mux, in 1 bpp (semigraphics/text) or 2 bpp (colour graphics) mode. Adds a one-word holding buffer with a valid/ready load handshake, a programmable pixel-clock divider and underrun detection. Sits between the VDG fetch/attribute logic and the colourMux.

Parameters:
DATA_W, 8, bits per fetched display word; must be even and >= 4
COLOUR_W, 4, width of colour and colour_index; must be >= 3
PIX_DIV, 1, clk cycles per pixel; 1..16

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  in_data/colour/mode present this cycle
load_ready  output  1  holding register can accept a word this cycle
in_data  input  DATA_W  display word; MSB is the first pixel
colour  input  COLOUR_W  foreground colour / palette base for this word
mode  input  1  0 = 1 bpp, 1 = 2 bpp; latched per word
active  input  1  high while in the visible line; gates underrun detection
pix_tick  output  1  high for one clk when a new pixel is presented
pix_valid  output  1  colour_index carries shifted pixel data
colour_index  output  COLOUR_W  current pixel colour index to colourMux
underrun  output  1  sticky; set on an active starvation, cleared by reset

Behaviour:
- Reset: all registers clear; load_ready=1, pix_tick=0, pix_valid=0, colour_index=0, underrun=0, divider=0, state IDLE, holding empty. Reset mid-line discards both words, with no underrun.
- Divider: div_cnt counts 0..PIX_DIV-1 and wraps. tick = (div_cnt==PIX_DIV-1). With PIX_DIV=1, tick is every cycle. div_cnt is forced to 0 on any IDLE->SHIFT transition, so the first pixel lasts a full PIX_DIV cycles.
- Holding register: stores {in_data, colour, mode}. Handshake: a word is accepted when load_valid && load_ready. load_ready = !hold_full || hold_xfer, where hold_xfer is the transfer into the shifter in the same cycle (one word per cycle is sustainable). load_valid without load_ready has no effect. The source must hold its data until accepted.
- Shifter state machine:
  - IDLE: pix_valid=0, colour_index=0. If hold_full, transfer on the next edge, enter SHIFT and present pixel 0. Latency from acceptance into an empty idle block to the first pixel_valid is 2 clk.
  - SHIFT: pixels per word NP = DATA_W (mode 0) or DATA_W/2 (mode 1). pix_cnt counts 0..NP-1. On tick, advance: shift left 1 (mode 0) or 2 (mode 1).
  - On tick at pix_cnt==NP-1:
    - If hold_full, transfer the next word (back-to-back, no gap).
    - Else go to IDLE. If active==1, set underrun.
- Pixel mapping (registered, updates with the shifter):
  - mode 0: colour_index = msb ? word_colour : 0.
  - mode 1: colour_index = {word_colour[COLOUR_W-1:2], top two bits}.
  - Mode and colour are per-word and change only at word boundaries.
- pix_tick is a one-cycle pulse coincident with each new pixel presentation, including the first pixel after IDLE. It is 0 in IDLE.
- Simultaneous accept and transfer in one cycle: the new word enters holding and the old word enters the shifter; hold_full stays 1.
- active low while starving: return to IDLE silently.

Optional Feature:
PIXEL_SHIFT_UNDERRUN_CNT_EN:
- Defined: adds output underrun_count [7:0], which increments on each underrun event and saturates at 255. It is cleared by reset. The underrun flag is unchanged.
- Undefined: the port and counter are absent; only the sticky flag exists.

Test Plan:
1. Reset, DATA_W=8, PIX_DIV=1, mode 0, colour=4'hA: load 8'hA5 once with active=0 -> pix_valid 2 clk after accept; colour_index sequence A,0,A,0,0,A,0,A. Then IDLE, underrun=0.
2. Mode 1, colour=4'hC, word 8'b00011011 -> indices C,D,E,F (4 pixels). pix_tick pulses on each.
3. PIX_DIV=3, mode 0, word 8'hFF -> each pixel is held 3 clk; pix_tick high every 3rd clk; 24 clk of valid output in total.
4. Back-to-back words 8'hF0 then 8'h0F with load_valid constantly high, active=1 -> 16 contiguous pixels with no gap; load_ready never drops for more than the holding interval; underrun=0 until the stream stops, then underrun=1.
5. load_valid held while the holding register is full and the shifter is mid-word -> load_ready=0 and the word is not taken until the last-pixel tick; no word lost or duplicated.
6. Assert reset mid-word (pixel 3 of 8) -> next cycle pix_valid=0, colour_index=0, load_ready=1, underrun=0; a subsequent load restarts at pixel 0.

Source files
------------

// File: rtl/pixel_shifter_if.sv
// Load-side bus of pixel_shifter: one display word plus its colour and
// mode, moved across a valid/ready handshake. The fetch/attribute logic
// drives the master side; the shifter is the slave.
interface pixel_shifter_if #(
  parameter int DATA_W   = 8,
  parameter int COLOUR_W = 4
);

  logic                load_valid;
  logic                load_ready;
  logic [DATA_W-1:0]   in_data;
  logic [COLOUR_W-1:0] colour;
  logic                mode;

  modport master (
    output load_valid,
    output in_data,
    output colour,
    output mode,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  in_data,
    input  colour,
    input  mode,
    output load_ready
  );

endinterface

// File: rtl/pixel_shifter.sv
// pixel_shifter
//   Serialises fetched display words into per-pixel colour indices for the
//   colour mux. Each word is shifted out MSB first, either one bit per pixel
//   (mode 0, semigraphics/text) or two bits per pixel (mode 1, colour
//   graphics). A single holding register in front of the shift register
//   lets the source deliver the next word while the current one is still
//   shifting, so words stream back-to-back with no pixel gap.
//
//   A programmable divider stretches every pixel to PIX_DIV clk cycles.
//   If a word finishes while nothing is waiting in the holding register,
//   the shifter falls back to idle; when this happens inside the visible
//   line (active high) the sticky underrun flag is set.
//
//   Optional build macro PIXEL_SHIFT_UNDERRUN_CNT_EN adds an 8-bit
//   saturating count of underrun events on port underrun_count.
module pixel_shifter #(
  parameter int DATA_W   = 8,   // even, >= 4
  parameter int COLOUR_W = 4,   // >= 3
  parameter int PIX_DIV  = 1    // clk cycles per pixel, 1..16
) (
  input  logic                clk,
  input  logic                reset,
  pixel_shifter_if.slave      load,
  input  logic                active,
  output logic                pix_tick,
  output logic                pix_valid,
  output logic [COLOUR_W-1:0] colour_index,
  output logic                underrun
`ifdef PIXEL_SHIFT_UNDERRUN_CNT_EN
  ,
  output logic [7:0]          underrun_count
`endif
);

  // pix_cnt must reach DATA_W-1 (the last pixel of a 1 bpp word).
  localparam int CNT_W = $clog2(DATA_W);
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_1BPP = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_2BPP = CNT_W'(DATA_W / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Holding register: the next word waiting for the shifter.
  logic                hold_full;
  logic [DATA_W-1:0]   hold_data;
  logic [COLOUR_W-1:0] hold_colour;
  logic                hold_mode;

  // Shifter: the word currently being displayed, with its attributes.
  logic [0:0]          state;
  logic [DATA_W-1:0]   shreg;
  logic [COLOUR_W-1:0] word_colour;
  logic                word_mode;
  logic [CNT_W-1:0]    pix_cnt;
  logic [DIV_W-1:0]    div_cnt;

  // Next-state values for the shifter and its registered outputs.
  logic [0:0]          state_nxt;
  logic [DATA_W-1:0]   shreg_nxt;
  logic [COLOUR_W-1:0] word_colour_nxt;
  logic                word_mode_nxt;
  logic [CNT_W-1:0]    pix_cnt_nxt;
  logic [DIV_W-1:0]    div_cnt_nxt;
  logic                pix_tick_nxt;
  logic                pix_valid_nxt;
  logic [COLOUR_W-1:0] colour_index_nxt;

  logic                tick;       // current pixel has run its PIX_DIV cycles
  logic                last_pix;   // current pixel is the last of its word
  logic                word_end;   // leaving the last pixel on this edge
  logic                hold_xfer;  // holding register -> shifter this edge
  logic                accept;     // new word -> holding register this edge
  logic                starve;     // word ended with nothing to follow it
  logic [DATA_W-1:0]   shifted;    // shreg advanced by one pixel

  // Colour index shown for the pixel sitting in the top bits of a word.
  function automatic logic [COLOUR_W-1:0] pixel_of(
    input logic [DATA_W-1:0]   w,
    input logic [COLOUR_W-1:0] c,
    input logic                m
  );
    if (m) begin
      // 2 bpp: the two data bits pick an entry within the palette group.
      pixel_of = {c[COLOUR_W-1:2], w[DATA_W-1 -: 2]};
    end else begin
      // 1 bpp: foreground where the bit is set, colour 0 elsewhere.
      pixel_of = w[DATA_W-1] ? c : '0;
    end
  endfunction

  // Handshake and word-boundary decode.
  assign tick      = (div_cnt == DIV_LAST);
  assign last_pix  = word_mode ? (pix_cnt == LAST_2BPP) : (pix_cnt == LAST_1BPP);
  assign word_end  = (state == ST_SHIFT) && tick && last_pix;
  assign hold_xfer = hold_full && ((state == ST_IDLE) || word_end);
  assign starve    = word_end && !hold_full;
  assign shifted   = word_mode ? {shreg[DATA_W-3:0], 2'b00}
                               : {shreg[DATA_W-2:0], 1'b0};

  // A slot is free when the register is empty or is being emptied this edge.
  assign load.load_ready = !hold_full || hold_xfer;
  assign accept          = load.load_valid && load.load_ready;

  // Holding register: accepts a word from the source; a simultaneous
  // transfer to the shifter leaves it full with the newly accepted word.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is assigned with <= so every register samples
    // the pre-edge values and block ordering cannot change behaviour.
    if (reset) begin
      hold_full   <= 1'b0;
      hold_data   <= '0;
      hold_colour <= '0;
      hold_mode   <= 1'b0;
    end else if (accept) begin
      hold_full   <= 1'b1;
      hold_data   <= load.in_data;
      hold_colour <= load.colour;
      hold_mode   <= load.mode;
    end else if (hold_xfer) begin
      hold_full   <= 1'b0;
    end
  end

  // Shifter next state: load a word, advance a pixel, or drop back to idle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt        = state;
    shreg_nxt        = shreg;
    word_colour_nxt  = word_colour;
    word_mode_nxt    = word_mode;
    pix_cnt_nxt      = pix_cnt;
    div_cnt_nxt      = div_cnt;
    pix_tick_nxt     = 1'b0;
    pix_valid_nxt    = pix_valid;
    colour_index_nxt = colour_index;

    if (hold_xfer) begin
      // New word: pixel 0 is presented now and lasts a full PIX_DIV cycles.
      state_nxt        = ST_SHIFT;
      shreg_nxt        = hold_data;
      word_colour_nxt  = hold_colour;
      word_mode_nxt    = hold_mode;
      pix_cnt_nxt      = '0;
      div_cnt_nxt      = '0;
      pix_tick_nxt     = 1'b1;
      pix_valid_nxt    = 1'b1;
      colour_index_nxt = pixel_of(hold_data, hold_colour, hold_mode);
    end else if (state == ST_SHIFT) begin
      if (word_end) begin
        // Word finished and nothing is queued behind it.
        state_nxt        = ST_IDLE;
        pix_cnt_nxt      = '0;
        div_cnt_nxt      = '0;
        pix_valid_nxt    = 1'b0;
        colour_index_nxt = '0;
      end else if (tick) begin
        shreg_nxt        = shifted;
        pix_cnt_nxt      = pix_cnt + 1'b1;
        div_cnt_nxt      = '0;
        pix_tick_nxt     = 1'b1;
        colour_index_nxt = pixel_of(shifted, word_colour, word_mode);
      end else begin
        div_cnt_nxt      = div_cnt + 1'b1;
      end
    end
  end

  // Shifter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      shreg        <= '0;
      word_colour  <= '0;
      word_mode    <= 1'b0;
      pix_cnt      <= '0;
      div_cnt      <= '0;
      pix_tick     <= 1'b0;
      pix_valid    <= 1'b0;
      colour_index <= '0;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      word_colour  <= word_colour_nxt;
      word_mode    <= word_mode_nxt;
      pix_cnt      <= pix_cnt_nxt;
      div_cnt      <= div_cnt_nxt;
      pix_tick     <= pix_tick_nxt;
      pix_valid    <= pix_valid_nxt;
      colour_index <= colour_index_nxt;
    end
  end

  // Sticky underrun: starving inside the visible line; blanking is benign.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (starve && active) begin
      underrun <= 1'b1;
    end
  end

`ifdef PIXEL_SHIFT_UNDERRUN_CNT_EN
  // Saturating count of underrun events, for field diagnostics.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (starve && active && (underrun_count != 8'hFF)) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule
